// File: rtl/audio_pkg.sv
// Shared types and widths for the SRAM audio streamer.
package audio_pkg;

  localparam int SRAM_AW  = 20;
  localparam int SAMPLE_W = 16;

  // Playback sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_FETCH = 2'd2,
    S_PLAY  = 2'd3
  } state_e;

  // Pass counter increments but sticks at its maximum value
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sram_read_port.sv
// Single-word SRAM read engine: drives CE/OE, times the access and
// captures the read data.
//
// Handshake: the requester holds start high for the whole access. While
// start is high CE/OE are asserted and an internal counter runs
// 0..READ_WAIT-1; done pulses for one cycle on the last count, and data
// holds the captured word from the following cycle until the next done.
// abort high suppresses done and capture for that cycle, so an access
// that is being torn down never updates data.
module sram_read_port
  import audio_pkg::*;
#(
  parameter int READ_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] sram_data,
  output logic                ce_n,
  output logic                oe_n,
  output logic                done,
  output logic [SAMPLE_W-1:0] data
);

  localparam logic [2:0] LAST_CNT = 3'(READ_WAIT - 1);

  logic [2:0]          cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] data_q, data_d;

  // Access strobes and completion pulse
  always_comb begin
    ce_n = ~start;
    oe_n = ~start;
    done = start & ~abort & (cnt_q == LAST_CNT);
  end

  // Wait counter and capture register next-state
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (!start || abort || done) begin
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end
    if (done) begin
      data_d = sram_data;
    end
  end

  // Counter and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/sram_audio_streamer.sv
// Streams 16-bit mono samples from a read-only SRAM to the codec
// interface, one sample per data_over rising edge. Handles codec init,
// song looping, pause (silence without advancing) and underrun flagging.
module sram_audio_streamer
  import audio_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] START_ADDR = 20'h00000,
  parameter logic [SRAM_AW-1:0] END_ADDR   = 20'h3FFFF,
  parameter int                 READ_WAIT  = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Enable,
  input  logic                Pause,
  output logic                INIT,
  input  logic                INIT_FINISH,
  input  logic                data_over,
  input  logic [SAMPLE_W-1:0] SRAM_Data,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                CE,
  output logic                UB,
  output logic                LB,
  output logic                OE,
  output logic                WE,
  output logic [SAMPLE_W-1:0] LDATA,
  output logic [SAMPLE_W-1:0] RDATA,
  output logic                Playing,
  output logic [7:0]          Loop_Count,
  output logic                Underrun,
  output state_e              dbg_state
);

  localparam logic [SRAM_AW-1:0] ADDR_ONE = SRAM_AW'(1);

  state_e              state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [SAMPLE_W-1:0] ldata_q, ldata_d;
  logic                buf_valid_q, buf_valid_d;
  logic [7:0]          loop_q, loop_d;
  logic                underrun_q, underrun_d;
  logic                dov_q, dov_d;

  logic                do_rise;
  logic                stop_req;
  logic                rd_start;
  logic                rd_done;
  logic                rd_ce_n;
  logic                rd_oe_n;
  logic [SAMPLE_W-1:0] next_buf;

  // Codec consumption edge and the "drop everything" request
  always_comb begin
    do_rise  = data_over & ~dov_q;
    stop_req = (state_q != S_IDLE) & ~Enable;
  end

  sram_read_port #(
    .READ_WAIT (READ_WAIT)
  ) u_read_port (
    .clk       (CLK),
    .rst_n     (RESET),
    .start     (rd_start),
    .abort     (stop_req),
    .sram_data (SRAM_Data),
    .ce_n      (rd_ce_n),
    .oe_n      (rd_oe_n),
    .done      (rd_done),
    .data      (next_buf)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; Enable low overrides every transition
  always_comb begin
    state_d = state_q;
    if (stop_req) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (Enable)      state_d = S_INIT;
        S_INIT:  if (INIT_FINISH) state_d = S_FETCH;
        S_FETCH: if (rd_done)     state_d = S_PLAY;
        S_PLAY:  if (do_rise && buf_valid_q && !Pause) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and fixed SRAM controls
  always_comb begin
    INIT      = (state_q == S_INIT);
    Playing   = (state_q == S_FETCH) || (state_q == S_PLAY);
    rd_start  = (state_q == S_FETCH);
    CE        = rd_ce_n;
    OE        = rd_oe_n;
    WE        = 1'b1;
    UB        = 1'b0;
    LB        = 1'b0;
    dbg_state = state_q;
  end

  // Datapath next-state: address walk, sample hand-off, counters, flags
  always_comb begin
    addr_d      = addr_q;
    ldata_d     = ldata_q;
    buf_valid_d = buf_valid_q;
    loop_d      = loop_q;
    underrun_d  = underrun_q;
    dov_d       = data_over;
    if (stop_req) begin
      // Rewind; pass count and underrun history survive a stop
      addr_d      = START_ADDR;
      ldata_d     = '0;
      buf_valid_d = 1'b0;
      dov_d       = 1'b0;
    end else begin
      if (rd_done) begin
        buf_valid_d = 1'b1;
        if (addr_q == END_ADDR) begin
          addr_d = START_ADDR;
          loop_d = sat_inc8(loop_q);
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      // Codec wanted a sample while the next one is still being read
      if ((state_q == S_FETCH) && do_rise) begin
        underrun_d = 1'b1;
      end
      if ((state_q == S_PLAY) && do_rise && buf_valid_q) begin
        if (Pause) begin
          ldata_d = '0;
        end else begin
          ldata_d     = next_buf;
          buf_valid_d = 1'b0;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q      <= START_ADDR;
      ldata_q     <= '0;
      buf_valid_q <= 1'b0;
      loop_q      <= 8'd0;
      underrun_q  <= 1'b0;
      dov_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      ldata_q     <= ldata_d;
      buf_valid_q <= buf_valid_d;
      loop_q      <= loop_d;
      underrun_q  <= underrun_d;
      dov_q       <= dov_d;
    end
  end

  assign SRAM_ADDR  = addr_q;
  assign LDATA      = ldata_q;
  assign RDATA      = ldata_q;
  assign Loop_Count = loop_q;
  assign Underrun   = underrun_q;

endmodule

// File: tb/tb_sram_audio_streamer.sv
// Bench for sram_audio_streamer with a 4-word song (END_ADDR=3) and
// READ_WAIT=2. SRAM returns addr+16'hA000 while CE/OE are low.
module tb_sram_audio_streamer;
  import audio_pkg::*;

  localparam logic [19:0] START_A = 20'h00000;
  localparam logic [19:0] END_A   = 20'h00003;
  localparam int          RW      = 2;
  localparam int          SONG_LEN = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Enable = 1'b0;
  logic        Pause = 1'b0;
  logic        INIT_FINISH = 1'b0;
  logic        data_over = 1'b0;
  logic        INIT;
  logic [15:0] SRAM_Data;
  logic [19:0] SRAM_ADDR;
  logic        CE, UB, LB, OE, WE;
  logic [15:0] LDATA, RDATA;
  logic        Playing;
  logic [7:0]  Loop_Count;
  logic        Underrun;
  state_e      dbg_state;

  sram_audio_streamer #(
    .START_ADDR (START_A),
    .END_ADDR   (END_A),
    .READ_WAIT  (RW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Enable      (Enable),
    .Pause       (Pause),
    .INIT        (INIT),
    .INIT_FINISH (INIT_FINISH),
    .data_over   (data_over),
    .SRAM_Data   (SRAM_Data),
    .SRAM_ADDR   (SRAM_ADDR),
    .CE          (CE),
    .UB          (UB),
    .LB          (LB),
    .OE          (OE),
    .WE          (WE),
    .LDATA       (LDATA),
    .RDATA       (RDATA),
    .Playing     (Playing),
    .Loop_Count  (Loop_Count),
    .Underrun    (Underrun),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / SRAM model ----------------
  always #10 CLK = ~CLK;

  assign SRAM_Data = (!CE && !OE) ? (SRAM_ADDR[15:0] + 16'hA000) : 16'h0BAD;

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          rd_idx;   // fetches done since playback (re)started
  int          wraps;    // total fetches of END_ADDR since reset
  logic [15:0] m_buf;    // sample the model holds ready for the codec

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read the next song word: addresses walk START..END and wrap
  task automatic model_fetch();
    int a;
    a = int'(START_A) + (rd_idx % SONG_LEN);
    if (a == int'(END_A)) wraps++;
    rd_idx++;
    m_buf = 16'(a) + 16'hA000;
  endtask

  // A consumption event: paused -> silence, else hand out and refill
  task automatic model_edge(input logic p);
    if (p) begin
      exp_q.push_back(16'h0000);
    end else begin
      exp_q.push_back(m_buf);
      model_fetch();
    end
  endtask

  function automatic logic [19:0] model_addr();
    return START_A + 20'(rd_idx % SONG_LEN);
  endfunction

  function automatic logic [7:0] model_loop();
    return (wraps > 255) ? 8'd255 : 8'(wraps);
  endfunction

  // ---------------- driver tasks ----------------
  // Enable, hold INIT_FINISH off for 5 cycles, then watch the first read
  task automatic do_init();
    int oe_low;
    @(negedge CLK);
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("init_high", 32'(INIT), 32'd1);
    end
    INIT_FINISH = 1'b1;
    @(negedge CLK);
    INIT_FINISH = 1'b0;
    chk("init_low_after_finish", 32'(INIT), 32'd0);
    chk("first_fetch_addr", 32'(SRAM_ADDR), 32'(START_A));
    chk("first_fetch_ce", 32'(CE), 32'd0);
    chk("playing_in_fetch", 32'(Playing), 32'd1);
    oe_low = (OE == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (OE == 1'b0) oe_low++;
      else break;
    end
    chk("oe_low_cycles", 32'(oe_low), 32'(RW));
    chk("ce_high_in_play", 32'(CE), 32'd1);
  endtask

  // One data_over pulse; ld is LDATA one cycle after the rising edge
  task automatic send_edge(input logic p, output logic [15:0] ld);
    @(negedge CLK);
    Pause = p;
    data_over = 1'b1;
    @(negedge CLK);
    data_over = 1'b0;
    ld = LDATA;
    repeat (4) @(negedge CLK);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        pause;
    logic [15:0] exp_ldata;
    logic [19:0] exp_addr;
    logic [7:0]  exp_loop;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] ld;
    logic [15:0] e;
    logic        p;

    vecs[0]  = '{1'b0, 16'hA000, 20'h2, 8'd0};
    vecs[1]  = '{1'b0, 16'hA001, 20'h3, 8'd0};
    vecs[2]  = '{1'b0, 16'hA002, 20'h0, 8'd1};
    vecs[3]  = '{1'b0, 16'hA003, 20'h1, 8'd1};
    vecs[4]  = '{1'b0, 16'hA000, 20'h2, 8'd1};
    vecs[5]  = '{1'b0, 16'hA001, 20'h3, 8'd1};
    vecs[6]  = '{1'b0, 16'hA002, 20'h0, 8'd2};
    vecs[7]  = '{1'b0, 16'hA003, 20'h1, 8'd2};
    vecs[8]  = '{1'b1, 16'h0000, 20'h1, 8'd2};
    vecs[9]  = '{1'b1, 16'h0000, 20'h1, 8'd2};
    vecs[10] = '{1'b0, 16'hA000, 20'h2, 8'd2};
    vecs[11] = '{1'b0, 16'hA001, 20'h3, 8'd2};

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_addr", 32'(SRAM_ADDR), 32'(START_A));
    chk("rst_ce", 32'(CE), 32'd1);
    chk("rst_oe", 32'(OE), 32'd1);
    chk("rst_we", 32'(WE), 32'd1);
    chk("rst_ub_lb", 32'({UB, LB}), 32'd0);
    chk("rst_ldata", 32'(LDATA), 32'd0);
    chk("rst_rdata", 32'(RDATA), 32'd0);
    chk("rst_init", 32'(INIT), 32'd0);
    chk("rst_playing", 32'(Playing), 32'd0);
    chk("rst_loop", 32'(Loop_Count), 32'd0);
    chk("rst_underrun", 32'(Underrun), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_without_enable", 32'(INIT), 32'd0);

    // ---- init handshake and first fetch ----
    do_init();

    // ---- table-driven playback, wrap and pause ----
    for (int i = 0; i < 12; i++) begin
      send_edge(vecs[i].pause, ld);
      chk($sformatf("vec%0d_ldata", i), 32'(ld), 32'(vecs[i].exp_ldata));
      chk($sformatf("vec%0d_rdata", i), 32'(RDATA), 32'(vecs[i].exp_ldata));
      chk($sformatf("vec%0d_addr", i), 32'(SRAM_ADDR), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_loop", i), 32'(Loop_Count), 32'(vecs[i].exp_loop));
    end
    chk("no_underrun_yet", 32'(Underrun), 32'd0);

    // ---- Enable dropped mid-fetch (fetch of END_ADDR abandoned) ----
    @(negedge CLK);
    Pause = 1'b0;
    data_over = 1'b1;
    @(negedge CLK);
    data_over = 1'b0;
    chk("drop_edge_ldata", 32'(LDATA), 32'hA002);
    Enable = 1'b0;
    @(negedge CLK);
    chk("drop_state", 32'(dbg_state), 32'(S_IDLE));
    chk("drop_ce", 32'(CE), 32'd1);
    chk("drop_oe", 32'(OE), 32'd1);
    chk("drop_addr", 32'(SRAM_ADDR), 32'(START_A));
    chk("drop_ldata", 32'(LDATA), 32'd0);
    chk("drop_playing", 32'(Playing), 32'd0);
    repeat (3) @(negedge CLK);
    chk("drop_loop_kept", 32'(Loop_Count), 32'd2);

    // ---- re-enable: INIT again, song restarts from START ----
    rd_idx = 0;
    wraps  = 2;
    do_init();
    model_fetch();

    // ---- randomized playback against the model ----
    for (int i = 0; i < 24; i++) begin
      p = ($urandom_range(0, 3) == 0);
      model_edge(p);
      send_edge(p, ld);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_ldata", i), 32'(ld), 32'(e));
      chk($sformatf("rnd%0d_addr", i), 32'(SRAM_ADDR), 32'(model_addr()));
      chk($sformatf("rnd%0d_loop", i), 32'(Loop_Count), 32'(model_loop()));
      repeat ($urandom_range(0, 6)) @(negedge CLK);
    end
    chk("rnd_no_underrun", 32'(Underrun), 32'd0);

    // ---- underrun: second edge lands on the fetch-completion cycle ----
    model_edge(1'b0);
    e = exp_q.pop_front();
    @(negedge CLK);
    Pause = 1'b0;
    data_over = 1'b1;
    @(negedge CLK);
    data_over = 1'b0;
    chk("ur_first_ldata", 32'(LDATA), 32'(e));
    @(negedge CLK);
    data_over = 1'b1;
    @(negedge CLK);
    data_over = 1'b0;
    chk("ur_set", 32'(Underrun), 32'd1);
    chk("ur_ldata_held", 32'(LDATA), 32'(e));
    repeat (4) @(negedge CLK);
    chk("ur_sticky", 32'(Underrun), 32'd1);
    chk("ur_addr", 32'(SRAM_ADDR), 32'(model_addr()));
    model_edge(1'b0);
    send_edge(1'b0, ld);
    e = exp_q.pop_front();
    chk("ur_next_sample", 32'(ld), 32'(e));
    chk("ur_still_set", 32'(Underrun), 32'd1);
    chk("ur_loop", 32'(Loop_Count), 32'(model_loop()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
